// File: rtl/pipe_stage_reg_if.sv
// Bundle for one inter-stage pipeline register: stall/flush control, per-lane
// upstream payload in, registered payload, delay-slot feedback and monitor outputs.
interface pipe_stage_reg_if #(
  parameter int DATA_W  = 32,
  parameter int LANES   = 1,
  parameter int STALL_W = 6,
  parameter int CNT_W   = 8
);
  logic [STALL_W-1:0]      stall;
  logic                    flush;
  logic [LANES-1:0]        in_valid;
  logic [LANES*DATA_W-1:0] in_data;
  logic [LANES-1:0]        in_wreg;
  logic [LANES*5-1:0]      in_wd;
  logic                    in_delayslot;
  logic                    next_delayslot_i;

  logic [LANES-1:0]        out_valid;
  logic [LANES*DATA_W-1:0] out_data;
  logic [LANES-1:0]        out_wreg;
  logic [LANES*5-1:0]      out_wd;
  logic                    out_delayslot;
  logic                    delayslot_o;
  logic                    bubble_o;
  logic [CNT_W-1:0]        hold_cnt;

  modport master (
    output stall, flush, in_valid, in_data, in_wreg, in_wd, in_delayslot, next_delayslot_i,
    input  out_valid, out_data, out_wreg, out_wd, out_delayslot, delayslot_o, bubble_o, hold_cnt
  );

  modport slave (
    input  stall, flush, in_valid, in_data, in_wreg, in_wd, in_delayslot, next_delayslot_i,
    output out_valid, out_data, out_wreg, out_wd, out_delayslot, delayslot_o, bubble_o, hold_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Multi-lane inter-stage pipeline register: 1-cycle latency, all outputs registered.
// Stall pair (STAGE, STAGE+1) selects advance, bubble or hold; flush clears, hold_cnt saturates.
module pipe_stage_reg #(
  parameter int               DATA_W    = 32,
  parameter int               LANES     = 1,
  parameter int               STALL_W   = 6,
  parameter int               STAGE     = 2,
  parameter int               CNT_W     = 8,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stage_reg_if.slave  bus
);

  localparam logic [LANES*DATA_W-1:0] NOP_ALL = {LANES{NOP_VALUE}};

  logic                    stall_up;
  logic                    stall_dn;
  logic                    unused_stall;

  logic [LANES-1:0]        valid_q, valid_d;
  logic [LANES*DATA_W-1:0] data_q, data_d;
  logic [LANES-1:0]        wreg_q, wreg_d;
  logic [LANES*5-1:0]      wd_q, wd_d;
  logic                    ds_q, ds_d;
  logic                    next_ds_q, next_ds_d;
  logic                    bubble_q, bubble_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  assign stall_up     = bus.stall[STAGE];
  assign stall_dn     = bus.stall[STAGE+1];
  assign unused_stall = ^bus.stall;

  // Upstream-free with downstream-stopped cannot come from a monotonic stall
  // controller; it falls through to advance rather than being special-cased.
  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    wreg_d    = wreg_q;
    wd_d      = wd_q;
    ds_d      = ds_q;
    next_ds_d = next_ds_q;
    bubble_d  = 1'b0;
    cnt_d     = cnt_q;
    if (bus.flush || (stall_up && !stall_dn)) begin
      valid_d   = '0;
      data_d    = NOP_ALL;
      wreg_d    = '0;
      wd_d      = '0;
      ds_d      = 1'b0;
      next_ds_d = 1'b0;
      cnt_d     = '0;
      bubble_d  = !bus.flush;
    end else if (!stall_up) begin
      valid_d   = bus.in_valid;
      data_d    = bus.in_data;
      wreg_d    = bus.in_wreg & bus.in_valid;
      wd_d      = bus.in_wd;
      ds_d      = bus.in_delayslot;
      next_ds_d = bus.next_delayslot_i;
      cnt_d     = '0;
    end else if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= '0;
      data_q    <= NOP_ALL;
      wreg_q    <= '0;
      wd_q      <= '0;
      ds_q      <= 1'b0;
      next_ds_q <= 1'b0;
      bubble_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      wreg_q    <= wreg_d;
      wd_q      <= wd_d;
      ds_q      <= ds_d;
      next_ds_q <= next_ds_d;
      bubble_q  <= bubble_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.out_valid     = valid_q;
  assign bus.out_data      = data_q;
  assign bus.out_wreg      = wreg_q;
  assign bus.out_wd        = wd_q;
  assign bus.out_delayslot = ds_q;
  assign bus.delayslot_o   = next_ds_q;
  assign bus.bubble_o      = bubble_q;
  assign bus.hold_cnt      = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg (2 lanes, 3-bit hold counter): directed
// scenarios then random traffic, each edge's expected outputs queued from a reference model.
module tb_pipe_stage_reg;

  localparam logic [31:0] NOP = 32'h0;

  typedef struct packed {
    logic [1:0]  v;
    logic [63:0] d;
    logic [1:0]  wr;
    logic [9:0]  wd;
    logic        ds;
    logic        dso;
    logic        bub;
    logic [2:0]  cnt;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  obs_t mdl;
  obs_t exp_q[$];
  event chk_ev;

  pipe_stage_reg_if #(.DATA_W(32), .LANES(2), .STALL_W(6), .CNT_W(3)) bus ();

  pipe_stage_reg #(
    .DATA_W(32), .LANES(2), .STALL_W(6), .STAGE(2), .CNT_W(3), .NOP_VALUE(NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t idle();
    obs_t o;
    o   = '0;
    o.d = {NOP, NOP};
    return o;
  endfunction

  // What the stage should show after one edge, stated rule by rule.
  function automatic obs_t step(input obs_t cur, input logic r, input logic [5:0] st,
                                input logic fl, input logic [1:0] v, input logic [63:0] d,
                                input logic [1:0] wr, input logic [9:0] wd,
                                input logic ids, input logic nds);
    obs_t n;
    n = idle();
    if (!r || fl) return n;
    if (!st[2]) begin
      n.v = v; n.d = d; n.wr = wr & v; n.wd = wd; n.ds = ids; n.dso = nds;
      return n;
    end
    if (!st[3]) begin
      n.bub = 1'b1;
      return n;
    end
    n     = cur;
    n.bub = 1'b0;
    n.cnt = (cur.cnt == 3'd7) ? 3'd7 : cur.cnt + 3'd1;
    return n;
  endfunction

  task automatic cycle(input logic r, input logic [5:0] st, input logic fl,
                       input logic [1:0] v, input logic [63:0] d, input logic [1:0] wr,
                       input logic [9:0] wd, input logic ids, input logic nds);
    @(negedge clk);
    rst                  = r;
    bus.stall            = st;
    bus.flush            = fl;
    bus.in_valid         = v;
    bus.in_data          = d;
    bus.in_wreg          = wr;
    bus.in_wd            = wd;
    bus.in_delayslot     = ids;
    bus.next_delayslot_i = nds;
    mdl = step(mdl, r, st, fl, v, d, wr, wd, ids, nds);
    exp_q.push_back(mdl);
  endtask

  task automatic rnd_cycle(input logic [5:0] st, input logic fl);
    cycle(1'b1, st, fl, 2'($urandom), {$urandom, $urandom}, 2'($urandom),
          10'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Reset dropped between edges: outputs must clear before the next edge.
  task automatic async_rst();
    @(negedge clk);
    #2;
    rst = 1'b0;
    mdl = idle();
    exp_q.push_back(mdl);
    ->chk_ev;
    exp_q.push_back(mdl);
  endtask

  initial begin : monitor
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (exp_q.size() > 0) begin
        e     = exp_q.pop_front();
        a.v   = bus.out_valid;
        a.d   = bus.out_data;
        a.wr  = bus.out_wreg;
        a.wd  = bus.out_wd;
        a.ds  = bus.out_delayslot;
        a.dso = bus.delayslot_o;
        a.bub = bus.bubble_o;
        a.cnt = bus.hold_cnt;
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL chk%0d t=%0t: got v=%b d=%h wr=%b wd=%h ds=%b dso=%b bub=%b cnt=%0d, want v=%b d=%h wr=%b wd=%h ds=%b dso=%b bub=%b cnt=%0d",
                   n_cmp, $time, a.v, a.d, a.wr, a.wd, a.ds, a.dso, a.bub, a.cnt,
                   e.v, e.d, e.wr, e.wd, e.ds, e.dso, e.bub, e.cnt);
        end
      end
    end
  end

  initial begin : stimulus
    bus.stall            = '0;
    bus.flush            = 1'b0;
    bus.in_valid         = '0;
    bus.in_data          = '0;
    bus.in_wreg          = '0;
    bus.in_wd            = '0;
    bus.in_delayslot     = 1'b0;
    bus.next_delayslot_i = 1'b0;
    mdl = idle();

    #1;
    rst = 1'b0;
    exp_q.push_back(mdl);
    ->chk_ev;

    repeat (2) cycle(1'b0, 6'h00, 1'b0, 2'b11, {$urandom, $urandom}, 2'b11, 10'h3ff, 1'b1, 1'b1);
    cycle(1'b1, 6'h00, 1'b0, 2'b01, {32'h0, 32'h1234_5678}, 2'b01, {5'd0, 5'd5}, 1'b0, 1'b0);

    cycle(1'b1, 6'b000111, 1'b0, 2'b11, {$urandom, $urandom}, 2'b11, 10'($urandom), 1'b1, 1'b1);

    cycle(1'b1, 6'h00, 1'b0, 2'b01, {32'h0, 32'h0000_00A5}, 2'b01, {5'd0, 5'd3}, 1'b0, 1'b0);
    repeat (10) rnd_cycle(6'b001111, 1'b0);
    rnd_cycle(6'h00, 1'b0);

    repeat (2) rnd_cycle(6'b001111, 1'b0);
    rnd_cycle(6'b001111, 1'b1);

    rnd_cycle(6'h00, 1'b0);
    repeat (2) rnd_cycle(6'b001111, 1'b0);
    async_rst();
    cycle(1'b0, 6'b001111, 1'b0, 2'b11, {$urandom, $urandom}, 2'b11, 10'($urandom), 1'b1, 1'b1);
    rnd_cycle(6'b001111, 1'b0);
    rnd_cycle(6'h00, 1'b0);

    cycle(1'b1, 6'h00, 1'b0, 2'b10, {$urandom, $urandom}, 2'b11, 10'($urandom), 1'b1, 1'b1);
    cycle(1'b1, 6'b000111, 1'b0, 2'b11, {$urandom, $urandom}, 2'b11, 10'($urandom), 1'b1, 1'b1);

    rnd_cycle(6'b001000, 1'b0);

    for (int i = 0; i < 400; i++) begin
      rnd_cycle(6'($urandom), ($urandom_range(0, 7) == 0));
    end

    @(posedge clk);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
